traffic_light_scheduler: RTL

TRAFFIC_LIGHT_SCHEDULER -- requirements
Module: traffic_light_scheduler

---
 rtl/traffic_light_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_scheduler.sv
`timescale 1ns/1ps
// Four-way traffic light sequencer with live-programmable phase durations and registered lamps.
// Define TLS_PED_EN to build in the pedestrian WALK phase, request latch and acknowledge pulse.
module traffic_light_scheduler #(
  parameter int TW       = 8,
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ped_req,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [TW-1:0] cfg_wdata,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          walk,
  output logic          ped_ack,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    ALLRED_NS = 3'd0,
    NS_G      = 3'd1,
    NS_Y      = 3'd2,
    ALLRED_EW = 3'd3,
    EW_G      = 3'd4,
    EW_Y      = 3'd5,
    WALK      = 3'd6
  } state_t;

  localparam logic [TW-1:0] ONE         = TW'(1);
  localparam logic [TW-1:0] DEF_GREEN   = (T_GREEN  == 0) ? ONE : TW'(T_GREEN);
  localparam logic [TW-1:0] DEF_YELLOW  = (T_YELLOW == 0) ? ONE : TW'(T_YELLOW);
  localparam logic [TW-1:0] DEF_ALLRED  = (T_ALLRED == 0) ? ONE : TW'(T_ALLRED);
  localparam logic [2:0]    LAMP_RED    = 3'b100;
  localparam logic [2:0]    LAMP_YELLOW = 3'b010;
  localparam logic [2:0]    LAMP_GREEN  = 3'b001;

  state_t        state_reg;
  state_t        state_next;
  logic [TW-1:0] t_reg;
  logic [TW-1:0] t_next;
  logic [TW-1:0] dur_green;
  logic [TW-1:0] dur_yellow;
  logic [TW-1:0] dur_allred;
  logic [TW-1:0] cur_dur;
  logic [TW-1:0] wdata_fixed;
  logic          phase_done;
  logic [2:0]    ns_next;
  logic [2:0]    ew_next;

`ifdef TLS_PED_EN
  localparam logic [TW-1:0] DEF_WALK = (T_WALK == 0) ? ONE : TW'(T_WALK);

  logic [TW-1:0] dur_walk;
  logic          ped_pending;
  logic          walk_entry;
`endif

  // A zero duration would make a phase vanish, so it is stored as the shortest legal phase.
  assign wdata_fixed = (cfg_wdata == '0) ? ONE : cfg_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dur_green  <= DEF_GREEN;
      dur_yellow <= DEF_YELLOW;
      dur_allred <= DEF_ALLRED;
`ifdef TLS_PED_EN
      dur_walk   <= DEF_WALK;
`endif
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0: dur_green  <= wdata_fixed;
        2'd1: dur_yellow <= wdata_fixed;
        2'd2: dur_allred <= wdata_fixed;
        2'd3: begin
`ifdef TLS_PED_EN
          dur_walk <= wdata_fixed;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_dur = dur_allred;
    case (state_reg)
      NS_G, EW_G: cur_dur = dur_green;
      NS_Y, EW_Y: cur_dur = dur_yellow;
`ifdef TLS_PED_EN
      WALK:       cur_dur = dur_walk;
`endif
      default:    cur_dur = dur_allred;
    endcase
  end

  // Durations are compared live, so a shortened register can end the current phase at once.
  assign phase_done = (t_reg >= (cur_dur - ONE));

  always_comb begin
    state_next = state_reg;
    if (phase_done) begin
      case (state_reg)
        ALLRED_NS: begin
`ifdef TLS_PED_EN
          state_next = ped_pending ? WALK : NS_G;
`else
          state_next = NS_G;
`endif
        end
        NS_G:      state_next = NS_Y;
        NS_Y:      state_next = ALLRED_EW;
        ALLRED_EW: state_next = EW_G;
        EW_G:      state_next = EW_Y;
        EW_Y:      state_next = ALLRED_NS;
        WALK:      state_next = NS_G;
        default:   state_next = ALLRED_NS;
      endcase
    end
  end

  assign t_next = (state_next != state_reg) ? '0 : (t_reg + ONE);

  always_comb begin
    ns_next = LAMP_RED;
    ew_next = LAMP_RED;
    case (state_next)
      NS_G:    ns_next = LAMP_GREEN;
      NS_Y:    ns_next = LAMP_YELLOW;
      EW_G:    ew_next = LAMP_GREEN;
      EW_Y:    ew_next = LAMP_YELLOW;
      default: ;
    endcase
  end

  // Lamps and phase are decoded from state_next so they flip on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ALLRED_NS;
      t_reg     <= '0;
      ns_light  <= LAMP_RED;
      ew_light  <= LAMP_RED;
      phase     <= 3'd0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      ns_light  <= ns_next;
      ew_light  <= ew_next;
      phase     <= state_next;
    end
  end

`ifdef TLS_PED_EN
  assign walk_entry = (state_next == WALK) && (state_reg != WALK);

  // Entry into WALK wins over a simultaneous request, so that request is served, not re-queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_pending <= 1'b0;
      walk        <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      if (walk_entry) begin
        ped_pending <= 1'b0;
      end else if (ped_req && (state_reg != WALK)) begin
        ped_pending <= 1'b1;
      end
      walk    <= (state_next == WALK);
      ped_ack <= walk_entry;
    end
  end
`else
  logic ped_unused;

  assign ped_unused = ped_req;
  assign walk       = 1'b0;
  assign ped_ack    = 1'b0;
`endif

  // Conflicting greens and walking into live traffic must be impossible.
  a_no_conflict: assert property (@(posedge clk) disable iff (!reset)
    !((ns_light != LAMP_RED) && (ew_light != LAMP_RED)));

  a_walk_safe: assert property (@(posedge clk) disable iff (!reset)
    walk |-> ((ns_light == LAMP_RED) && (ew_light == LAMP_RED)));

endmodule
